// File: rtl/noc_pkg.sv
// noc_pkg: channel IDs, flit type codes and header field positions shared by the router blocks
package noc_pkg;
  localparam logic [2:0] LOCAL = 3'b000;
  localparam logic [2:0] NORTH = 3'b001;
  localparam logic [2:0] SOUTH = 3'b010;
  localparam logic [2:0] EAST  = 3'b011;
  localparam logic [2:0] WEST  = 3'b100;
  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;
  // field MSB positions measured down from FLIT_W
  localparam int TYPE_MSB_OFS = 1;
  localparam int X_MSB_OFS    = 3;
  localparam int Y_MSB_OFS    = 5;
  typedef enum logic [1:0] {IDLE, ROUTE, ACTIVE} icc_state_e;
  function automatic logic is_head(input logic [1:0] t);
    return t[0];
  endfunction
  function automatic logic is_tail(input logic [1:0] t);
    return t[1];
  endfunction
endpackage

// File: rtl/flit_fifo.sv
// flit_fifo: DEPTH x W circular flit buffer with occupancy count and sync reset
module flit_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] front,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  always_comb begin
    wr_d  = wr_q + AW'(push);
    rd_d  = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end
  assign front = mem_q[rd_q];
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
endmodule

// File: rtl/input_channel_controller.sv
// input_channel_controller: buffers input flits, latches the head route and forwards
// one flit per switch-allocator grant until the tail of the wormhole packet
module input_channel_controller
  import noc_pkg::*;
#(
  parameter int FLIT_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [1:0]        x_d,
  output logic [1:0]        y_d,
  input  logic [2:0]        rout_id,
  output logic              sa_req,
  output logic [2:0]        sa_port,
  input  logic              sa_grant,
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_valid,
  output logic              err_drop
);
  icc_state_e state_q, state_d;
  logic [1:0] xdst_q, xdst_d, ydst_q, ydst_d;
  logic [2:0] port_q, port_d;
  logic push, pop, full, empty;
  logic [FLIT_W-1:0] front;
  logic [1:0] ftype;
  flit_fifo #(.W(FLIT_W), .DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (in_flit),
    .pop  (pop),
    .front(front),
    .full (full),
    .empty(empty)
  );
  assign ftype    = front[FLIT_W-TYPE_MSB_OFS -: 2];
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;
  assign out_flit = front;
  assign x_d      = xdst_q;
  assign y_d      = ydst_q;
  assign sa_port  = port_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      xdst_q  <= '0;
      ydst_q  <= '0;
      port_q  <= '0;
    end else begin
      state_q <= state_d;
      xdst_q  <= xdst_d;
      ydst_q  <= ydst_d;
      port_q  <= port_d;
    end
  end
  always_comb begin
    state_d = state_q;
    xdst_d  = xdst_q;
    ydst_d  = ydst_q;
    port_d  = port_q;
    unique case (state_q)
      IDLE: if (!empty && is_head(ftype)) begin
        state_d = ROUTE;
        xdst_d  = front[FLIT_W-X_MSB_OFS -: 2];
        ydst_d  = front[FLIT_W-Y_MSB_OFS -: 2];
      end
      ROUTE: begin
        state_d = ACTIVE;
        port_d  = rout_id;
      end
      ACTIVE: state_d = (out_valid && is_tail(ftype)) ? IDLE : ACTIVE;
      default: state_d = IDLE;
    endcase
  end
  // a head inside a packet is just forwarded; only IDLE discards non-head flits
  always_comb begin
    sa_req    = state_q == ACTIVE && !empty && !rst;
    out_valid = sa_req && sa_grant;
    err_drop  = state_q == IDLE && !empty && !is_head(ftype) && !rst;
    pop       = out_valid || err_drop;
  end
endmodule

// File: tb/tb_input_channel_controller.sv
// tb_input_channel_controller: directed scenarios with a behavioural XY channel coordinator
module tb_input_channel_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] in_flit = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [1:0] x_d, y_d;
  logic [2:0] rout_id;
  logic sa_req;
  logic [2:0] sa_port;
  logic sa_grant = 1'b0;
  logic [15:0] out_flit;
  logic out_valid, err_drop;
  logic [1:0] xr = 2'd1, yr = 2'd2;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  always_comb rout_id = x_d > xr ? 3'b011 : x_d < xr ? 3'b100 :
                        y_d > yr ? 3'b001 : y_d < yr ? 3'b010 : 3'b000;

  input_channel_controller #(.FLIT_W(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .x_d(x_d), .y_d(y_d), .rout_id(rout_id), .sa_req(sa_req), .sa_port(sa_port),
    .sa_grant(sa_grant), .out_flit(out_flit), .out_valid(out_valid), .err_drop(err_drop)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; sa_grant = 1'b0;
    cyc(); cyc(); #2;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    tests++; if (sa_req !== 1'b0) begin fails++; $display("FAIL rst_sa_req got=%b exp=0", sa_req); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    tests++; if (err_drop !== 1'b0) begin fails++; $display("FAIL rst_err_drop got=%b exp=0", err_drop); end
    tests++; if ({x_d, y_d} !== 4'h0) begin fails++; $display("FAIL rst_xy got=%h exp=0", {x_d, y_d}); end
    tests++; if (sa_port !== 3'd0) begin fails++; $display("FAIL rst_sa_port got=%0d exp=0", sa_port); end
    rst = 1'b0; #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready got=%b exp=1", in_ready); end
    cyc();
  endtask

  task automatic test_packet();
    xr = 2'd1; yr = 2'd2; sa_grant = 1'b1;
    in_flit = 16'h7C00; in_valid = 1'b1; cyc();
    in_flit = 16'h0004; #2;
    tests++; if (sa_req !== 1'b0) begin fails++; $display("FAIL pkt_early_req got=%b exp=0", sa_req); end
    cyc();
    in_flit = 16'h8005; #2;
    tests++; if ({x_d, y_d} !== {2'd3, 2'd3}) begin fails++; $display("FAIL pkt_xy got=%h exp=f", {x_d, y_d}); end
    tests++; if (sa_req !== 1'b0) begin fails++; $display("FAIL pkt_route_req got=%b exp=0", sa_req); end
    cyc();
    in_valid = 1'b0; #2;
    tests++; if (sa_port !== 3'b011) begin fails++; $display("FAIL pkt_sa_port got=%b exp=011", sa_port); end
    tests++; if (sa_req !== 1'b1) begin fails++; $display("FAIL pkt_req got=%b exp=1", sa_req); end
    tests++; if ({out_valid, out_flit} !== {1'b1, 16'h7C00}) begin fails++; $display("FAIL pkt_head got=%b/%h exp=1/7c00", out_valid, out_flit); end
    cyc(); #2;
    tests++; if ({out_valid, out_flit} !== {1'b1, 16'h0004}) begin fails++; $display("FAIL pkt_body got=%b/%h exp=1/0004", out_valid, out_flit); end
    cyc(); #2;
    tests++; if ({out_valid, out_flit} !== {1'b1, 16'h8005}) begin fails++; $display("FAIL pkt_tail got=%b/%h exp=1/8005", out_valid, out_flit); end
    cyc(); #2;
    tests++; if ({sa_req, out_valid} !== 2'b00) begin fails++; $display("FAIL pkt_idle got=%b exp=00", {sa_req, out_valid}); end
  endtask

  task automatic test_single();
    xr = 2'd0; yr = 2'd0;
    in_flit = 16'hC000; in_valid = 1'b1; cyc();
    in_valid = 1'b0; #2;
    tests++; if (sa_req !== 1'b0) begin fails++; $display("FAIL sgl_early_req got=%b exp=0", sa_req); end
    cyc(); #2;
    tests++; if ({x_d, y_d} !== 4'h0) begin fails++; $display("FAIL sgl_xy got=%h exp=0", {x_d, y_d}); end
    cyc(); #2;
    tests++; if (sa_port !== 3'b000) begin fails++; $display("FAIL sgl_sa_port got=%b exp=000", sa_port); end
    tests++; if ({sa_req, out_valid, out_flit} !== {2'b11, 16'hC000}) begin fails++; $display("FAIL sgl_out got=%b%b/%h exp=11/c000", sa_req, out_valid, out_flit); end
    cyc(); #2;
    tests++; if ({sa_req, out_valid} !== 2'b00) begin fails++; $display("FAIL sgl_idle got=%b exp=00", {sa_req, out_valid}); end
  endtask

  task automatic test_stray();
    xr = 2'd1; yr = 2'd2; sa_grant = 1'b1;
    in_flit = 16'h0123; in_valid = 1'b1; cyc();
    in_flit = 16'h4400; #2;
    tests++; if (err_drop !== 1'b1) begin fails++; $display("FAIL stray_drop got=%b exp=1", err_drop); end
    tests++; if (sa_req !== 1'b0) begin fails++; $display("FAIL stray_req got=%b exp=0", sa_req); end
    cyc();
    in_valid = 1'b0; #2;
    tests++; if (err_drop !== 1'b0) begin fails++; $display("FAIL stray_drop_len got=%b exp=0", err_drop); end
    cyc(); #2;
    tests++; if ({x_d, y_d} !== {2'd0, 2'd1}) begin fails++; $display("FAIL stray_xy got=%h exp=1", {x_d, y_d}); end
    cyc(); #2;
    tests++; if (sa_port !== 3'b100) begin fails++; $display("FAIL stray_sa_port got=%b exp=100", sa_port); end
    tests++; if ({out_valid, out_flit} !== {1'b1, 16'h4400}) begin fails++; $display("FAIL stray_head got=%b/%h exp=1/4400", out_valid, out_flit); end
    cyc(); #2;
    tests++; if ({sa_req, sa_port} !== {1'b0, 3'b100}) begin fails++; $display("FAIL stray_starve got=%b/%b exp=0/100", sa_req, sa_port); end
    in_flit = 16'h8000; in_valid = 1'b1; cyc();
    in_valid = 1'b0; #2;
    tests++; if ({out_valid, out_flit} !== {1'b1, 16'h8000}) begin fails++; $display("FAIL stray_tail got=%b/%h exp=1/8000", out_valid, out_flit); end
    cyc(); #2;
    tests++; if ({sa_req, err_drop} !== 2'b00) begin fails++; $display("FAIL stray_idle got=%b exp=00", {sa_req, err_drop}); end
  endtask

  task automatic test_full();
    logic [15:0] v [4];
    v = '{16'h7C00, 16'h0001, 16'h0002, 16'h8003};
    xr = 2'd1; yr = 2'd2; sa_grant = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin in_flit = v[i]; cyc(); end
    in_flit = 16'h0BAD; #2;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_ready got=%b exp=0", in_ready); end
    tests++; if ({sa_req, out_valid, sa_port} !== {2'b10, 3'b011}) begin fails++; $display("FAIL full_wait got=%b%b/%b exp=10/011", sa_req, out_valid, sa_port); end
    cyc();
    in_valid = 1'b0; sa_grant = 1'b1; #2;
    tests++; if ({in_ready, out_valid, out_flit} !== {2'b01, 16'h7C00}) begin fails++; $display("FAIL full_grant got=%b%b/%h exp=01/7c00", in_ready, out_valid, out_flit); end
    cyc();
    sa_grant = 1'b0; #2;
    tests++; if ({in_ready, out_valid, out_flit} !== {2'b10, 16'h0001}) begin fails++; $display("FAIL full_release got=%b%b/%h exp=10/0001", in_ready, out_valid, out_flit); end
    sa_grant = 1'b1; #1;
    tests++; if ({out_valid, out_flit} !== {1'b1, 16'h0001}) begin fails++; $display("FAIL full_b1 got=%b/%h exp=1/0001", out_valid, out_flit); end
    cyc(); #2;
    tests++; if ({out_valid, out_flit} !== {1'b1, 16'h0002}) begin fails++; $display("FAIL full_b2 got=%b/%h exp=1/0002", out_valid, out_flit); end
    cyc(); #2;
    tests++; if ({out_valid, out_flit} !== {1'b1, 16'h8003}) begin fails++; $display("FAIL full_tail got=%b/%h exp=1/8003", out_valid, out_flit); end
    cyc(); #2;
    tests++; if ({sa_req, err_drop, in_ready} !== 3'b001) begin fails++; $display("FAIL full_drain got=%b exp=001", {sa_req, err_drop, in_ready}); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v [4];
    v = '{16'h7000, 16'h8001, 16'h4000, 16'h8002};
    xr = 2'd1; yr = 2'd2; sa_grant = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin in_flit = v[i]; cyc(); end
    in_flit = v[3]; #2;
    tests++; if ({sa_req, sa_port} !== {1'b1, 3'b011}) begin fails++; $display("FAIL b2b_p1 got=%b/%b exp=1/011", sa_req, sa_port); end
    tests++; if ({out_valid, out_flit} !== {1'b1, 16'h7000}) begin fails++; $display("FAIL b2b_h1 got=%b/%h exp=1/7000", out_valid, out_flit); end
    cyc();
    in_valid = 1'b0; #2;
    tests++; if ({out_valid, out_flit} !== {1'b1, 16'h8001}) begin fails++; $display("FAIL b2b_t1 got=%b/%h exp=1/8001", out_valid, out_flit); end
    cyc(); #2;
    tests++; if (sa_req !== 1'b0) begin fails++; $display("FAIL b2b_gap1 got=%b exp=0", sa_req); end
    cyc(); #2;
    tests++; if ({sa_req, x_d, y_d} !== 5'b0) begin fails++; $display("FAIL b2b_gap2 got=%b exp=00000", {sa_req, x_d, y_d}); end
    cyc(); #2;
    tests++; if ({sa_req, sa_port, out_flit} !== {1'b1, 3'b100, 16'h4000}) begin fails++; $display("FAIL b2b_p2 got=%b/%b/%h exp=1/100/4000", sa_req, sa_port, out_flit); end
    cyc(); #2;
    tests++; if ({out_valid, out_flit} !== {1'b1, 16'h8002}) begin fails++; $display("FAIL b2b_t2 got=%b/%h exp=1/8002", out_valid, out_flit); end
    cyc(); #2;
    tests++; if (sa_req !== 1'b0) begin fails++; $display("FAIL b2b_idle got=%b exp=0", sa_req); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] v [4];
    v = '{16'h7C00, 16'h0001, 16'h0002, 16'h8003};
    xr = 2'd1; yr = 2'd2; sa_grant = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin in_flit = v[i]; cyc(); end
    in_valid = 1'b0; #2;
    tests++; if ({out_valid, out_flit} !== {1'b1, 16'h0001}) begin fails++; $display("FAIL rmid_b1 got=%b/%h exp=1/0001", out_valid, out_flit); end
    cyc();
    rst = 1'b1; #2;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rmid_ready got=%b exp=0", in_ready); end
    cyc(); #2;
    tests++; if ({sa_req, out_valid, err_drop, x_d, y_d, sa_port} !== 10'b0) begin fails++; $display("FAIL rmid_outs got=%b exp=0", {sa_req, out_valid, err_drop, x_d, y_d, sa_port}); end
    rst = 1'b0; cyc(); #2;
    tests++; if ({sa_req, err_drop, in_ready} !== 3'b001) begin fails++; $display("FAIL rmid_flushed got=%b exp=001", {sa_req, err_drop, in_ready}); end
    in_flit = 16'hC800; in_valid = 1'b1; cyc();
    in_valid = 1'b0; cyc(); #2;
    tests++; if ({x_d, y_d} !== {2'd0, 2'd2}) begin fails++; $display("FAIL rmid_xy got=%h exp=2", {x_d, y_d}); end
    cyc(); #2;
    tests++; if ({sa_req, sa_port, out_valid, out_flit} !== {1'b1, 3'b100, 1'b1, 16'hC800}) begin fails++; $display("FAIL rmid_new got=%b/%b/%b/%h exp=1/100/1/c800", sa_req, sa_port, out_valid, out_flit); end
    cyc(); #2;
    tests++; if (sa_req !== 1'b0) begin fails++; $display("FAIL rmid_idle got=%b exp=0", sa_req); end
  endtask

  initial begin
    test_reset();
    test_packet();
    test_single();
    test_stray();
    test_full();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
